// File: rtl/alu_ctrl_if.sv
// Instruction and result channels between an instruction source and alu_ctrl.
// The source drives the instruction fields; alu_ctrl drives ready and the result pulse.
interface alu_ctrl_if #(
    parameter int unsigned W   = 8,
    parameter int unsigned OPW = 3,
    parameter int unsigned RW  = 2
);
    logic           instr_valid;
    logic           instr_ready;
    logic [OPW-1:0] instr_op;
    logic [RW-1:0]  instr_rd;
    logic [RW-1:0]  instr_rs;
    logic [W-1:0]   instr_imm;
    logic           res_valid;
    logic [RW-1:0]  res_rd;
    logic [W-1:0]   res_data;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs, instr_imm,
        input  instr_ready, res_valid, res_rd, res_data
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs, instr_imm,
        output instr_ready, res_valid, res_rd, res_data
    );
endinterface

// File: rtl/alu_ctrl.sv
// Execute controller: reads operands from a local register file, issues them to an
// external combinational ALU, and writes the result and Zero/Sign flags back.
module alu_ctrl #(
    parameter int unsigned W    = 8,
    parameter int unsigned OPW  = 3,
    parameter int unsigned NREG = 4,
    localparam int unsigned RW  = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_ctrl_if.slave      bus,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_zero,
    input  logic           alu_sign,
    output logic           flag_z,
    output logic           flag_s,
    output logic           err,
    input  logic [RW-1:0]  dbg_sel,
    output logic [W-1:0]   dbg_data
);
    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SHR = OPW'(1);
    localparam logic [OPW-1:0] OP_SHL = OPW'(2);
    localparam logic [OPW-1:0] OP_XOR = OPW'(3);
    localparam logic [OPW-1:0] OP_LDI = OPW'(4);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    rf [NREG];
    logic [RW-1:0]   issue_rd;

    logic            rf_we;
    logic [RW-1:0]   rf_wa;
    logic [W-1:0]    rf_wd;
    logic            flag_we;
    logic            fz_nx, fs_nx;
    logic            issue_ld;
    logic            err_nx;
    logic            clamp;

    assign dbg_data = rf[dbg_sel];

    // Next state, writeback selection and issue control
    always_comb begin
        state_nx = state;
        rf_we    = 1'b0;
        rf_wa    = bus.instr_rd;
        rf_wd    = bus.instr_imm;
        flag_we  = 1'b0;
        fz_nx    = flag_z;
        fs_nx    = flag_s;
        issue_ld = 1'b0;
        err_nx   = 1'b0;
        // Shifts by W or more have an ALU-defined result; force a clean zero instead
        clamp    = ((alu_op == OP_SHR) || (alu_op == OP_SHL)) && (32'(alu_b) >= W);
        case (state)
            IDLE: begin
                if (bus.instr_valid && bus.instr_ready) begin
                    case (bus.instr_op)
                        OP_ADD, OP_SHR, OP_SHL, OP_XOR: begin
                            issue_ld = 1'b1;
                            state_nx = EXEC;
                        end
                        OP_LDI:  rf_we  = 1'b1;
                        default: err_nx = 1'b1;
                    endcase
                end
            end
            EXEC: begin
                state_nx = IDLE;
                rf_we    = 1'b1;
                rf_wa    = issue_rd;
                flag_we  = 1'b1;
                if (clamp) begin
                    rf_wd = '0;
                    fz_nx = 1'b1;
                    fs_nx = 1'b0;
                end else begin
                    rf_wd = alu_out;
                    fz_nx = alu_zero;
                    fs_nx = alu_sign;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control state, issue registers, flags and result pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.instr_ready <= 1'b1;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_op          <= '0;
            issue_rd        <= '0;
            flag_z          <= 1'b0;
            flag_s          <= 1'b0;
            err             <= 1'b0;
            bus.res_valid   <= 1'b0;
            bus.res_rd      <= '0;
            bus.res_data    <= '0;
        end else begin
            state           <= state_nx;
            bus.instr_ready <= (state_nx == IDLE);
            err             <= err_nx;
            bus.res_valid   <= rf_we;
            if (issue_ld) begin
                alu_a    <= rf[bus.instr_rd];
                alu_b    <= rf[bus.instr_rs];
                alu_op   <= bus.instr_op;
                issue_rd <= bus.instr_rd;
            end
            if (flag_we) begin
                flag_z <= fz_nx;
                flag_s <= fs_nx;
            end
            if (rf_we) begin
                bus.res_rd   <= rf_wa;
                bus.res_data <= rf_wd;
            end
        end
    end

    // Register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (rf_we) begin
            rf[rf_wa] <= rf_wd;
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU plus an architectural register/flag model,
// directed scenarios followed by a randomized instruction stream.
module tb_alu_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_op;
    logic       alu_zero, alu_sign;
    logic       flag_z, flag_s, err;
    logic [1:0] dbg_sel = 2'd0;
    logic [7:0] dbg_data;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0] mreg [4];
    logic       mz, ms;
    logic [1:0] last_rd;
    logic [7:0] last_data;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .alu_zero (alu_zero),
        .alu_sign (alu_sign),
        .flag_z   (flag_z),
        .flag_s   (flag_s),
        .err      (err),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // ALU stand-in; shift amounts wrap mod 8 so oversized shifts yield nonzero junk
    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a >> alu_b[2:0];
            3'd2:    alu_out = alu_a << alu_b[2:0];
            3'd3:    alu_out = alu_a ^ alu_b;
            default: alu_out = 8'hxx;
        endcase
        alu_zero = (alu_out == 8'd0);
        alu_sign = alu_out[7];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result of an ALU-class instruction: {zero, sign, value}
    function automatic logic [9:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = (b >= 8) ? 8'd0 : (a >> b);
            3'd2:    r = (b >= 8) ? 8'd0 : (a << b);
            default: r = a ^ b;
        endcase
        return {(r == 8'd0), r[7], r};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mreg[i] = 8'd0;
        mz = 1'b0; ms = 1'b0;
        last_rd = 2'd0; last_data = 8'd0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check(tag, 32'(dbg_data), 32'(mreg[i]));
        end
    endtask

    // Offer one instruction starting now (away from an edge) and check its outcome
    task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
        logic [7:0]  a, b, exp;
        logic        ez, es;
        int unsigned waited;
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs    = rs;
        bus.instr_imm   = imm;
        dbg_sel         = rd;
        waited = 0;
        while (!bus.instr_ready && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.instr_ready) begin
            check("accept_timeout", 32'(bus.instr_ready), 32'd1);
            bus.instr_valid = 1'b0;
            return;
        end
        a = mreg[rd];
        b = mreg[rs];
        @(posedge clk); #1;
        if (op <= 3'd3) begin
            check("exec_ready", 32'(bus.instr_ready), 32'd0);
            check("exec_res_valid", 32'(bus.res_valid), 32'd0);
            check("exec_err", 32'(err), 32'd0);
            check("alu_a", 32'(alu_a), 32'(a));
            check("alu_b", 32'(alu_b), 32'(b));
            check("alu_op", 32'(alu_op), 32'(op));
            check("dbg_before_wb", 32'(dbg_data), 32'(a));
            {ez, es, exp} = ref_alu(op, a, b);
            @(posedge clk); #1;
            mreg[rd] = exp; mz = ez; ms = es;
        end else if (op == 3'd4) begin
            mreg[rd] = imm;
            exp = imm;
        end else begin
            exp = 8'd0;
        end
        if (op <= 3'd4) begin
            check("res_valid", 32'(bus.res_valid), 32'd1);
            check("res_rd", 32'(bus.res_rd), 32'(rd));
            check("res_data", 32'(bus.res_data), 32'(exp));
            check("err_quiet", 32'(err), 32'd0);
            last_rd = rd; last_data = exp;
        end else begin
            check("err_pulse", 32'(err), 32'd1);
            check("err_no_res", 32'(bus.res_valid), 32'd0);
        end
        check("ready_back", 32'(bus.instr_ready), 32'd1);
        check("flag_z", 32'(flag_z), 32'(mz));
        check("flag_s", 32'(flag_s), 32'(ms));
        check("dbg_after", 32'(dbg_data), 32'(mreg[rd]));
    endtask

    task automatic idle();
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_res_valid", 32'(bus.res_valid), 32'd0);
        check("idle_err", 32'(err), 32'd0);
        check("hold_res_rd", 32'(bus.res_rd), 32'(last_rd));
        check("hold_res_data", 32'(bus.res_data), 32'(last_data));
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_op = 3'd0; bus.instr_rd = 2'd0; bus.instr_rs = 2'd0; bus.instr_imm = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_res_rd", 32'(bus.res_rd), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        check("rst_flags", 32'({flag_z, flag_s}), 32'd0);
        check_regs("rst_reg");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // LDI pair back to back, then ADD
        send(3'd4, 2'd0, 2'd0, 8'h05);
        send(3'd4, 2'd1, 2'd0, 8'h03);
        send(3'd0, 2'd0, 2'd1, 8'h00);
        idle();
        check("add_result", 32'(mreg[0]), 32'h08);

        // XOR of equal values sets Zero
        send(3'd4, 2'd2, 2'd0, 8'hAA);
        send(3'd4, 2'd3, 2'd0, 8'hAA);
        send(3'd3, 2'd2, 2'd3, 8'h00);
        idle();

        // SHL by 9 clamps regardless of the ALU output
        send(3'd4, 2'd3, 2'd0, 8'd9);
        send(3'd4, 2'd0, 2'd0, 8'h05);
        send(3'd2, 2'd0, 2'd3, 8'h00);
        idle();
        send(3'd1, 2'd1, 2'd3, 8'h00);
        idle();

        // Two ADDs with valid held high
        send(3'd4, 2'd0, 2'd0, 8'h81);
        send(3'd0, 2'd0, 2'd0, 8'h00);
        send(3'd0, 2'd1, 2'd0, 8'h00);
        idle();

        // Illegal opcode: error pulse, nothing written
        send(3'd6, 2'd2, 2'd1, 8'hFF);
        idle();
        check_regs("illegal_regs");

        // Reset during EXEC aborts the ADD
        bus.instr_valid = 1'b1; bus.instr_op = 3'd0; bus.instr_rd = 2'd1; bus.instr_rs = 2'd0;
        @(posedge clk); #1;
        check("abort_exec", 32'(bus.instr_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(bus.instr_ready), 32'd1);
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        check("abort_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        bus.instr_valid = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(bus.instr_ready), 32'd1);
        check("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("post_rst_flags", 32'({flag_z, flag_s}), 32'd0);
        check_regs("post_rst_reg");

        // Randomized stream
        for (int n = 0; n < 300; n++) begin
            logic [2:0] op;
            logic [7:0] imm;
            op  = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            imm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            send(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), imm);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        check_regs("final_regs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Multi-cycle execute controller that sits in front of the combinational ALU and drives its A/B/OP inputs. It accepts register-to-register instructions over a valid/ready handshake, reads operands from a local 4-entry register file, and issues the operation to the ALU. It then captures the ALU result and Zero/Sign flags back into the register file and a flag register, and reports each completed instruction with a one-cycle result pulse.

## Interface
- W, 8, datapath width; must match the ALU.
- OPW, 3, opcode width; must match the ALU.
- NREG, 4, register file depth; register index width is log2(NREG) = 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept an instruction this cycle.
- instr_op  in  OPW  000 ADD, 001 SHR, 010 SHL, 011 XOR, 100 LDI, 101–111 illegal.
- instr_rd  in  2  destination register, also the first operand.
- instr_rs  in  2  second operand register.
- instr_imm  in  W  immediate; used only by LDI.
- alu_a  out  W  ALU operand A.
- alu_b  out  W  ALU operand B.
- alu_op  out  OPW  ALU opcode.
- alu_out  in  W  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_zero  in  1  ALU Zero flag.
- alu_sign  in  1  ALU Sign flag.
- res_valid  out  1  one-cycle pulse: an instruction completed and wrote back.
- res_rd  out  2  register written; valid with res_valid.
- res_data  out  W  value written; valid with res_valid.
- flag_z  out  1  registered Zero flag.
- flag_s  out  1  registered Sign flag.
- err  out  1  one-cycle pulse: illegal opcode was accepted and dropped.
- dbg_sel  in  2  register file read select.
- dbg_data  out  W  combinational read of reg[dbg_sel].

## Operation
- FSM states:
  - IDLE: instr_ready=1.
  - EXEC: instr_ready=0.
- Handshake: an instruction is accepted on a rising edge where instr_valid and instr_ready are both 1. Fields are sampled on that edge only.
- IDLE, accept ALU op (000–011):
  - Latch A=reg[rd], B=reg[rs], op, and rd into issue registers.
  - Go to EXEC.
- EXEC:
  - alu_a, alu_b, and alu_op are driven from the issue registers and held stable for the whole cycle.
  - On the exit edge: reg[rd] <= alu_out; flag_z <= alu_zero; flag_s <= alu_sign, unmodified.
  - Return to IDLE.
- Shift clamp:
  - For SHR/SHL with B >= W, the ALU result is ignored.
  - The controller writes 0, sets flag_z=1 and flag_s=0.
  - alu_b is still driven with B.
- LDI: on the acceptance edge, reg[rd] <= instr_imm. Flags are unchanged. The state stays IDLE.
- Illegal op (101–111):
  - No register or flag write.
  - err pulses.
  - The state stays IDLE.
- rd == rs is legal: both operands read the same pre-write value.
- In IDLE, alu_a, alu_b, and alu_op hold their last issued values. They are not meaningful outside EXEC.
- dbg_data reflects a write starting the cycle after the write edge.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - state=IDLE, instr_ready=1
  - all reg[]=0, flag_z=0, flag_s=0
  - res_valid=0, err=0
  - res_rd=0, res_data=0
  - alu_a=0, alu_b=0, alu_op=000
- ALU op accepted at edge T:
  - EXEC during cycle T..T+1.
  - Writeback at edge T+1.
  - res_valid=1 for exactly the cycle after edge T+1, with res_rd/res_data equal to the written value.
  - instr_ready=1 again in that same cycle.
- Throughput: one ALU op per 2 cycles.
- LDI accepted at edge T: res_valid=1, res_rd=rd, res_data=imm in the cycle after T. instr_ready stays 1, so back-to-back LDIs give 1 per cycle.
- Illegal op accepted at edge T: err=1 in the cycle after T. res_valid=0.
- instr_valid during EXEC is ignored. The offering side must hold it until accepted.
- Reset asserted during EXEC aborts the instruction: no writeback and no res_valid. All outputs go to reset values immediately.
- res_rd and res_data keep their last values while res_valid=0.

## Test plan
- Reset, then LDI r0=0x05, LDI r1=0x03, then ADD rd=0 rs=1:
  - LDI pulses appear on consecutive cycles.
  - ADD gives res_valid 2 cycles after acceptance with res_rd=0, res_data=0x08.
  - dbg_sel=0 reads 0x08.
- XOR r2=0xAA with r3=0xAA:
  - res_data=0x00, flag_z=1.
  - flag_s equals the alu_sign the ALU presented.
- SHL with reg[rs]=9 (>= W):
  - res_data=0, flag_z=1, flag_s=0, regardless of alu_out.
- instr_valid held high with ADD, ADD:
  - instr_ready toggles 1,0,1,0.
  - Exactly two res_valid pulses, 2 cycles apart.
- Opcode 110 accepted:
  - err=1 for one cycle.
  - No res_valid; registers and flags unchanged.
- Assert rst_n=0 mid-EXEC of ADD, then release:
  - No res_valid.
  - All registers and flags read 0.
  - instr_ready=1 on the first cycle after release.
